// File: rtl/renode_arb_pkg.sv
// Shared types and byte-enable decoding for the Renode bus arbiter.
package renode_arb_pkg;

  localparam int unsigned MaxBeW = 16;

  typedef enum logic [2:0] {
    ActGetByte        = 3'd0,
    ActGetWord        = 3'd1,
    ActGetDoubleWord  = 3'd2,
    ActGetQuadWord    = 3'd3,
    ActPushByte       = 3'd4,
    ActPushWord       = 3'd5,
    ActPushDoubleWord = 3'd6,
    ActPushQuadWord   = 3'd7
  } action_e;

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StSend,
    StWaitRsp,
    StResp
  } state_e;

  typedef struct packed {
    logic    valid;
    action_e action;
  } be_decode_t;

  // Only low-lane masks of 1, 2, 4 or 8 bytes map onto a Renode access size.
  function automatic be_decode_t be_to_action(input logic [MaxBeW-1:0] be, input logic write);
    be_decode_t res;
    logic [1:0] size;
    res.valid = 1'b1;
    size      = 2'd0;
    case (be)
      16'h0001: size = 2'd0;
      16'h0003: size = 2'd1;
      16'h000F: size = 2'd2;
      16'h00FF: size = 2'd3;
      default:  res.valid = 1'b0;
    endcase
    res.action = action_e'({write, size});
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: the first requester at or after the pointer wins and the
// pointer then moves just past the winner.
module rr_arbiter
  import renode_arb_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic [N-1:0]    grant,
  output logic [IdxW-1:0] idx,
  output logic            any
);

  logic [IdxW-1:0] ptr;
  logic [IdxW:0]   cand;

  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (IdxW+1)'(ptr) + (IdxW+1)'(k);
      if (cand >= (IdxW+1)'(N)) cand = cand - (IdxW+1)'(N);
      if (!any && req[cand[IdxW-1:0]]) begin
        any = 1'b1;
        idx = cand[IdxW-1:0];
      end
    end
    grant = any ? (N'(1) << idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (idx == IdxW'(N - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/renode_bus_arbiter.sv
// Round-robin sequencer sharing one Renode message channel among NUM_REQ requesters.
// Define RENODE_ARB_TIMEOUT_EN to add the read-response timeout (TMO_CYC cycles).
module renode_bus_arbiter
  import renode_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TMO_CYC = 1024
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ-1:0]            req_write_i,
  input  logic [NUM_REQ*DATA_W/8-1:0]   req_be_i,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]     req_wdata_i,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [DATA_W-1:0]             rsp_rdata_o,
  output logic                          rsp_err_o,
  output logic                          msg_valid_o,
  input  logic                          msg_ready_i,
  output action_e                       msg_action_o,
  output logic [ADDR_W-1:0]             msg_addr_o,
  output logic [DATA_W-1:0]             msg_data_o,
  input  logic                          in_valid_i,
  input  logic [DATA_W-1:0]             in_data_i,
  output logic                          busy_o
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16 || BE_W > MaxBeW || TMO_CYC < 1) begin : g_param_check
    $fatal(1, "renode_bus_arbiter: unsupported parameter set");
  end

  state_e             state;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic               arb_advance;

  logic [NUM_REQ-1:0] gnt_q;
  logic               write_q;
  logic [BE_W-1:0]    be_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  be_decode_t         dec;

`ifdef RENODE_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  assign arb_advance = (state == StIdle) && arb_any;
  assign dec         = be_to_action(MaxBeW'(be_q), write_q);
  assign busy_o      = (state != StIdle);

  rr_arbiter #(
    .N    (NUM_REQ),
    .IdxW (IDX_W)
  ) u_rr (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .req     (req_valid_i),
    .advance (arb_advance),
    .grant   (arb_grant),
    .idx     (arb_idx),
    .any     (arb_any)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state        <= StIdle;
      gnt_q        <= '0;
      write_q      <= 1'b0;
      be_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_ready_o  <= '0;
      rsp_valid_o  <= '0;
      rsp_rdata_o  <= '0;
      rsp_err_o    <= 1'b0;
      msg_valid_o  <= 1'b0;
      msg_action_o <= ActGetByte;
      msg_addr_o   <= '0;
      msg_data_o   <= '0;
`ifdef RENODE_ARB_TIMEOUT_EN
      tmo_cnt      <= '0;
`endif
    end else begin
      req_ready_o <= '0;
      rsp_valid_o <= '0;
      unique case (state)
        StIdle: begin
          if (arb_any) begin
            req_ready_o <= arb_grant;
            gnt_q       <= arb_grant;
            write_q     <= req_write_i[arb_idx];
            be_q        <= req_be_i[arb_idx*BE_W +: BE_W];
            addr_q      <= req_addr_i[arb_idx*ADDR_W +: ADDR_W];
            wdata_q     <= req_wdata_i[arb_idx*DATA_W +: DATA_W];
            state       <= StDecode;
          end
        end
        StDecode: begin
          if (dec.valid) begin
            msg_valid_o  <= 1'b1;
            msg_action_o <= dec.action;
            msg_addr_o   <= addr_q;
            msg_data_o   <= write_q ? wdata_q : '0;
            state        <= StSend;
          end else begin
            // Unsupported mask: answer with an error without touching the channel.
            rsp_valid_o <= gnt_q;
            rsp_err_o   <= 1'b1;
            rsp_rdata_o <= '0;
            state       <= StResp;
          end
        end
        StSend: begin
          if (msg_ready_i) begin
            msg_valid_o  <= 1'b0;
            msg_action_o <= ActGetByte;
            msg_addr_o   <= '0;
            msg_data_o   <= '0;
            if (write_q) begin
              rsp_valid_o <= gnt_q;
              rsp_err_o   <= 1'b0;
              rsp_rdata_o <= '0;
              state       <= StResp;
            end else begin
              state <= StWaitRsp;
`ifdef RENODE_ARB_TIMEOUT_EN
              tmo_cnt <= '0;
`endif
            end
          end
        end
        StWaitRsp: begin
          if (in_valid_i) begin
            rsp_valid_o <= gnt_q;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= in_data_i;
            state       <= StResp;
          end
`ifdef RENODE_ARB_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(TMO_CYC - 1)) begin
            rsp_valid_o <= gnt_q;
            rsp_err_o   <= 1'b1;
            rsp_rdata_o <= '0;
            state       <= StResp;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        StResp: begin
          rsp_err_o   <= 1'b0;
          rsp_rdata_o <= '0;
          state       <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
